rs_issue_queue: RTL and testbench



---
 rtl/rs_issue_queue_pkg.sv | 16 +
 rtl/rs_issue_queue_if.sv | 59 +++++
 rtl/rs_issue_queue_age_matrix.sv | 54 +++++
 rtl/rs_issue_queue.sv | 181 ++++++++++++++++++
 tb/tb_rs_issue_queue.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_issue_queue_pkg.sv
// Shared constants, default widths and CDB slicing helper
// for the ALU reservation station.
`define RS_CDB_SLICE(bus, k, w) bus[(k)*(w) +: (w)]

package rs_defs;

  localparam int DEF_DEPTH   = 8;
  localparam int DEF_NUM_CDB = 2;
  localparam int DEF_TAG_W   = 4;
  localparam int DEF_VAL_W   = 32;
  localparam int DEF_OP_W    = 6;

  // ROB tag 0 marks an operand whose value is already present
  localparam int TAG_NONE = 0;

endpackage

// File: rtl/rs_issue_queue_if.sv
// Decode, CDB and ALU dispatch bundle for rs_issue_queue.
// master drives requests and broadcasts, slave is the station.
interface rs_issue_queue_if
  import rs_defs::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_CDB = DEF_NUM_CDB,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int VAL_W   = DEF_VAL_W,
  parameter int OP_W    = DEF_OP_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     dec_valid;
  logic [OP_W-1:0]          dec_op;
  logic [TAG_W-1:0]         dec_tag;
  logic [VAL_W-1:0]         dec_v1;
  logic [VAL_W-1:0]         dec_v2;
  logic [TAG_W-1:0]         dec_q1;
  logic [TAG_W-1:0]         dec_q2;
  logic [31:0]              dec_pc;
  logic [VAL_W-1:0]         dec_imm;
  logic                     full;
  logic [CNT_W-1:0]         count;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*VAL_W-1:0] cdb_val;
  logic                     ex_valid;
  logic                     ex_ready;
  logic [OP_W-1:0]          ex_op;
  logic [TAG_W-1:0]         ex_tag;
  logic [VAL_W-1:0]         ex_v1;
  logic [VAL_W-1:0]         ex_v2;
  logic [31:0]              ex_pc;
  logic [VAL_W-1:0]         ex_imm;

  modport master (
    output dec_valid, dec_op, dec_tag,
    output dec_v1, dec_v2, dec_q1, dec_q2,
    output dec_pc, dec_imm,
    output cdb_valid, cdb_tag, cdb_val,
    output ex_ready,
    input  full, count, ex_valid,
    input  ex_op, ex_tag, ex_v1, ex_v2,
    input  ex_pc, ex_imm
  );

  modport slave (
    input  dec_valid, dec_op, dec_tag,
    input  dec_v1, dec_v2, dec_q1, dec_q2,
    input  dec_pc, dec_imm,
    input  cdb_valid, cdb_tag, cdb_val,
    input  ex_ready,
    output full, count, ex_valid,
    output ex_op, ex_tag, ex_v1, ex_v2,
    output ex_pc, ex_imm
  );

endinterface

// File: rtl/rs_issue_queue_age_matrix.sv
// Age matrix: row i holds the entries older than entry i,
// giving a one-hot pick of the oldest ready entry.
module rs_age_matrix
  import rs_defs::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     i_alloc_en,
  input  logic [$clog2(DEPTH)-1:0] i_alloc_idx,
  input  logic [DEPTH-1:0]         i_free_mask,
  input  logic [DEPTH-1:0]         i_ready_mask,
  input  logic                     i_clear,
  output logic [DEPTH-1:0]         o_oldest_oh,
  output logic                     o_oldest_vld
);

  logic [DEPTH-1:0][DEPTH-1:0] r_older;
  logic [DEPTH-1:0][DEPTH-1:0] w_nxt;

  // Stale bits of idle rows are harmless: the ready mask
  // hides them and allocation wipes the new column.
  always_comb begin
    w_nxt = r_older;
    if (i_alloc_en) begin
      for (int i = 0; i < DEPTH; i++)
        w_nxt[i][i_alloc_idx] = 1'b0;
      w_nxt[i_alloc_idx] = ~(DEPTH'(1) << i_alloc_idx);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i_free_mask[i]) begin
        w_nxt[i] = '0;
        for (int j = 0; j < DEPTH; j++)
          w_nxt[j][i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in || i_clear)
      r_older <= '0;
    else
      r_older <= w_nxt;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      o_oldest_oh[i] = i_ready_mask[i] &&
        ((r_older[i] & i_ready_mask) == '0);
    o_oldest_vld = |i_ready_mask;
  end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation station: renamed-operand storage, CDB wakeup,
// oldest-ready select and a registered ALU dispatch port.
module rs_issue_queue
  import rs_defs::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_CDB = DEF_NUM_CDB,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int VAL_W   = DEF_VAL_W,
  parameter int OP_W    = DEF_OP_W
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  rs_issue_queue_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);
  localparam int TV_W = TAG_W + VAL_W;

  logic [DEPTH-1:0] r_busy;
  logic [OP_W-1:0]  r_op  [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [TAG_W-1:0] r_q1  [DEPTH];
  logic [TAG_W-1:0] r_q2  [DEPTH];
  logic [VAL_W-1:0] r_v1  [DEPTH];
  logic [VAL_W-1:0] r_v2  [DEPTH];
  logic [VAL_W-1:0] r_imm [DEPTH];
  logic [31:0]      r_pc  [DEPTH];

  logic             r_ex_valid;
  logic [OP_W-1:0]  r_ex_op;
  logic [TAG_W-1:0] r_ex_tag;
  logic [VAL_W-1:0] r_ex_v1;
  logic [VAL_W-1:0] r_ex_v2;
  logic [31:0]      r_ex_pc;
  logic [VAL_W-1:0] r_ex_imm;

  logic [TAG_W-1:0] w_q1n [DEPTH];
  logic [TAG_W-1:0] w_q2n [DEPTH];
  logic [VAL_W-1:0] w_v1n [DEPTH];
  logic [VAL_W-1:0] w_v2n [DEPTH];
  logic [TAG_W-1:0] w_dq1, w_dq2;
  logic [VAL_W-1:0] w_dv1, w_dv2;
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_sel_oh;
  logic             w_sel_vld;
  logic [IDX_W-1:0] w_sel_idx;
  logic [IDX_W-1:0] w_free_idx;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_issue;
  logic             w_disp;
  logic             w_en;

  // Descending scan so the lowest channel wins a tag tie
  function automatic logic [TV_W-1:0] snoop(
    input logic [TAG_W-1:0]         q,
    input logic [VAL_W-1:0]         v,
    input logic [NUM_CDB-1:0]       cv,
    input logic [NUM_CDB*TAG_W-1:0] ct,
    input logic [NUM_CDB*VAL_W-1:0] cd
  );
    logic [TV_W-1:0] res;
    res = {q, v};
    if (q != NO_TAG)
      for (int k = NUM_CDB - 1; k >= 0; k--)
        if (cv[k] && `RS_CDB_SLICE(ct, k, TAG_W) == q)
          res = {NO_TAG, `RS_CDB_SLICE(cd, k, VAL_W)};
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {w_q1n[i], w_v1n[i]} = snoop(r_q1[i], r_v1[i],
        bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      {w_q2n[i], w_v2n[i]} = snoop(r_q2[i], r_v2[i],
        bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
    end
    {w_dq1, w_dv1} = snoop(bus.dec_q1, bus.dec_v1,
      bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
    {w_dq2, w_dv2} = snoop(bus.dec_q2, bus.dec_v2,
      bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
  end

  always_comb begin
    w_count    = '0;
    w_free_idx = '0;
    w_sel_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = r_busy[i] && r_q1[i] == NO_TAG
                   && r_q2[i] == NO_TAG;
      w_count = w_count + CNT_W'(r_busy[i]);
      if (w_sel_oh[i])
        w_sel_idx = w_sel_idx | IDX_W'(i);
    end
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!r_busy[i])
        w_free_idx = IDX_W'(i);
  end

  assign w_full  = (w_count == CNT_W'(DEPTH));
  assign w_issue = bus.dec_valid && !w_full;
  assign w_disp  = w_sel_vld && (!r_ex_valid || bus.ex_ready);
  assign w_en    = rdy_in && !flush;

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk          (clk),
    .rst_in       (rst_in),
    .i_alloc_en   (w_en && w_issue),
    .i_alloc_idx  (w_free_idx),
    .i_free_mask  ((w_en && w_disp) ? w_sel_oh : '0),
    .i_ready_mask (w_ready),
    .i_clear      (rdy_in && flush),
    .o_oldest_oh  (w_sel_oh),
    .o_oldest_vld (w_sel_vld)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_busy     <= '0;
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_tag   <= '0;
      r_ex_v1    <= '0;
      r_ex_v2    <= '0;
      r_ex_pc    <= '0;
      r_ex_imm   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        r_busy     <= '0;
        r_ex_valid <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          r_q1[i] <= w_q1n[i];
          r_v1[i] <= w_v1n[i];
          r_q2[i] <= w_q2n[i];
          r_v2[i] <= w_v2n[i];
        end
        if (w_disp) begin
          r_busy[w_sel_idx] <= 1'b0;
          r_ex_valid <= 1'b1;
          r_ex_op    <= r_op[w_sel_idx];
          r_ex_tag   <= r_tag[w_sel_idx];
          r_ex_v1    <= r_v1[w_sel_idx];
          r_ex_v2    <= r_v2[w_sel_idx];
          r_ex_pc    <= r_pc[w_sel_idx];
          r_ex_imm   <= r_imm[w_sel_idx];
        end else if (bus.ex_ready) begin
          r_ex_valid <= 1'b0;
        end
        // Free slot wins over the wakeup write of an idle entry
        if (w_issue) begin
          r_busy[w_free_idx] <= 1'b1;
          r_op[w_free_idx]   <= bus.dec_op;
          r_tag[w_free_idx]  <= bus.dec_tag;
          r_q1[w_free_idx]   <= w_dq1;
          r_v1[w_free_idx]   <= w_dv1;
          r_q2[w_free_idx]   <= w_dq2;
          r_v2[w_free_idx]   <= w_dv2;
          r_pc[w_free_idx]   <= bus.dec_pc;
          r_imm[w_free_idx]  <= bus.dec_imm;
        end
      end
    end
  end

  assign bus.full     = w_full;
  assign bus.count    = w_count;
  assign bus.ex_valid = r_ex_valid;
  assign bus.ex_op    = r_ex_op;
  assign bus.ex_tag   = r_ex_tag;
  assign bus.ex_v1    = r_ex_v1;
  assign bus.ex_v2    = r_ex_v2;
  assign bus.ex_pc    = r_ex_pc;
  assign bus.ex_imm   = r_ex_imm;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Scoreboard bench for rs_issue_queue: directed issue, wakeup,
// ordering, backpressure, flush, freeze and reset scenarios.
module tb_rs_issue_queue;
  import rs_defs::*;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  rs_issue_queue_if bus ();

  rs_issue_queue dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  tag;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] pc;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int n_checks = 0;
  int n_err = 0;

  function automatic logic [31:0] pc_of(logic [3:0] t);
    return 32'h1000 + {26'd0, t, 2'b00};
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic dec(input logic [5:0] op,
                     input logic [3:0] tag,
                     input logic [31:0] v1,
                     input logic [3:0] q1,
                     input logic [31:0] v2,
                     input logic [3:0] q2);
    bus.dec_valid = 1'b1;
    bus.dec_op    = op;
    bus.dec_tag   = tag;
    bus.dec_v1    = v1;
    bus.dec_q1    = q1;
    bus.dec_v2    = v2;
    bus.dec_q2    = q2;
    bus.dec_pc    = pc_of(tag);
    bus.dec_imm   = {28'd0, tag};
  endtask

  task automatic idle();
    bus.dec_valid = 1'b0;
  endtask

  task automatic push(input logic [5:0] op,
                      input logic [3:0] tag,
                      input logic [31:0] v1,
                      input logic [31:0] v2);
    exp_t e;
    e.op  = op;
    e.tag = tag;
    e.v1  = v1;
    e.v2  = v2;
    e.pc  = pc_of(tag);
    e.imm = {28'd0, tag};
    sb.push_back(e);
  endtask

  task automatic cdb(input logic [1:0] vld,
                     input logic [3:0] t1, input logic [3:0] t0,
                     input logic [31:0] d1,
                     input logic [31:0] d0);
    bus.cdb_valid = vld;
    bus.cdb_tag   = {t1, t0};
    bus.cdb_val   = {d1, d0};
  endtask

  // Monitor: every accepted dispatch must match the queue head
  always @(negedge clk) begin
    if (!rst_in && rdy_in && !flush
        && bus.ex_valid && bus.ex_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_dispatch: got tag %h expected none",
                 bus.ex_tag);
      end else begin
        m_e = sb.pop_front();
        chk("ex_tag", 32'(bus.ex_tag), 32'(m_e.tag));
        chk("ex_op", 32'(bus.ex_op), 32'(m_e.op));
        chk("ex_v1", bus.ex_v1, m_e.v1);
        chk("ex_v2", bus.ex_v2, m_e.v2);
        chk("ex_pc", bus.ex_pc, m_e.pc);
        chk("ex_imm", bus.ex_imm, m_e.imm);
      end
    end
  end

  initial begin
    bus.dec_valid = 1'b0;
    bus.dec_op    = '0;
    bus.dec_tag   = '0;
    bus.dec_v1    = '0;
    bus.dec_v2    = '0;
    bus.dec_q1    = '0;
    bus.dec_q2    = '0;
    bus.dec_pc    = '0;
    bus.dec_imm   = '0;
    bus.ex_ready  = 1'b1;
    cdb(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);

    step();
    step();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_ex_tag", 32'(bus.ex_tag), 32'd0);
    chk("rst_ex_v1", bus.ex_v1, 32'd0);
    rst_in = 1'b0;

    // Ready operands: dispatch two edges after issue
    dec(6'd1, 4'd3, 32'd5, 4'd0, 32'd7, 4'd0);
    push(6'd1, 4'd3, 32'd5, 32'd7);
    step();
    idle();
    chk("t1_count_issue", 32'(bus.count), 32'd1);
    chk("t1_not_early", 32'(bus.ex_valid), 32'd0);
    step();
    chk("t1_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("t1_count_disp", 32'(bus.count), 32'd0);
    step();

    // Wakeup from CDB channel 1
    dec(6'd2, 4'd4, 32'd0, 4'd2, 32'd1, 4'd0);
    push(6'd2, 4'd4, 32'h55, 32'd1);
    step();
    idle();
    cdb(2'b10, 4'd2, 4'd0, 32'h55, 32'd0);
    chk("t2_waiting", 32'(bus.ex_valid), 32'd0);
    step();
    cdb(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    chk("t2_not_early", 32'(bus.ex_valid), 32'd0);
    step();
    chk("t2_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("t2_ex_v1", bus.ex_v1, 32'h55);
    step();

    // Same-cycle issue bypass from channel 0
    dec(6'd3, 4'd5, 32'd3, 4'd0, 32'd0, 4'd6);
    cdb(2'b01, 4'd0, 4'd6, 32'd0, 32'd9);
    push(6'd3, 4'd5, 32'd3, 32'd9);
    step();
    idle();
    cdb(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    chk("t3_not_early", 32'(bus.ex_valid), 32'd0);
    step();
    chk("t3_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("t3_ex_v2", bus.ex_v2, 32'd9);
    step();

    // Duplicate tag on both channels: channel 0 wins
    dec(6'd4, 4'd7, 32'd0, 4'd8, 32'd2, 4'd0);
    push(6'd4, 4'd7, 32'hA, 32'd2);
    step();
    idle();
    cdb(2'b11, 4'd8, 4'd8, 32'hB, 32'hA);
    step();
    cdb(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    step();
    chk("cdb_prio_v1", bus.ex_v1, 32'hA);
    step();

    // Fill under backpressure, then drain in issue order
    bus.ex_ready = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      dec(6'd5, 4'(t), 32'(t), 4'd0, 32'(t + 16), 4'd0);
      push(6'd5, 4'(t), 32'(t), 32'(t + 16));
      step();
    end
    idle();
    chk("fill_count", 32'(bus.count), 32'd8);
    chk("fill_full", 32'(bus.full), 32'd1);
    dec(6'd5, 4'd10, 32'd10, 4'd0, 32'd26, 4'd0);
    step();
    idle();
    chk("full_ignored", 32'(bus.count), 32'd8);
    chk("hold_tag", 32'(bus.ex_tag), 32'd1);
    chk("hold_valid", 32'(bus.ex_valid), 32'd1);
    bus.ex_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("b2b_valid", 32'(bus.ex_valid), 32'd1);
      step();
    end
    chk("drain_valid", 32'(bus.ex_valid), 32'd0);
    chk("drain_count", 32'(bus.count), 32'd0);
    chk("drain_full", 32'(bus.full), 32'd0);

    // Younger ready entry overtakes an older waiting one
    dec(6'd6, 4'd11, 32'd0, 4'd12, 32'd1, 4'd0);
    step();
    dec(6'd6, 4'd13, 32'd2, 4'd0, 32'd3, 4'd0);
    step();
    idle();
    push(6'd6, 4'd13, 32'd2, 32'd3);
    push(6'd6, 4'd11, 32'h77, 32'd1);
    cdb(2'b01, 4'd0, 4'd12, 32'd0, 32'h77);
    step();
    cdb(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    chk("age_young_ready", 32'(bus.ex_tag), 32'd13);
    step();
    chk("age_old_woken", 32'(bus.ex_tag), 32'd11);
    step();

    // Both wake together: older goes first
    dec(6'd7, 4'd1, 32'd0, 4'd14, 32'd4, 4'd0);
    step();
    dec(6'd7, 4'd2, 32'd5, 4'd0, 32'd0, 4'd15);
    step();
    idle();
    push(6'd7, 4'd1, 32'd1, 32'd4);
    push(6'd7, 4'd2, 32'd5, 32'd2);
    cdb(2'b11, 4'd15, 4'd14, 32'd2, 32'd1);
    step();
    cdb(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    step();
    chk("age_older_first", 32'(bus.ex_tag), 32'd1);
    step();
    chk("age_younger_next", 32'(bus.ex_tag), 32'd2);
    step();

    // Five busy plus one held in the output register
    bus.ex_ready = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      dec(6'd8, 4'(t), 32'(t), 4'd0, 32'd0, 4'd0);
      step();
    end
    idle();
    chk("pre_flush_count", 32'(bus.count), 32'd5);
    chk("pre_flush_valid", 32'(bus.ex_valid), 32'd1);

    // Frozen: request, broadcast and ready are all ignored
    rdy_in = 1'b0;
    bus.ex_ready = 1'b1;
    dec(6'd8, 4'd7, 32'd7, 4'd0, 32'd0, 4'd0);
    cdb(2'b01, 4'd0, 4'd3, 32'd0, 32'hEE);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze_count", 32'(bus.count), 32'd5);
      chk("freeze_valid", 32'(bus.ex_valid), 32'd1);
      chk("freeze_tag", 32'(bus.ex_tag), 32'd1);
    end
    cdb(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);

    bus.ex_ready = 1'b0;
    rdy_in = 1'b1;
    flush = 1'b1;
    dec(6'd8, 4'd9, 32'd9, 4'd0, 32'd0, 4'd0);
    step();
    flush = 1'b0;
    idle();
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    bus.ex_ready = 1'b1;
    step();
    step();
    chk("flush_drop_count", 32'(bus.count), 32'd0);
    chk("flush_drop_valid", 32'(bus.ex_valid), 32'd0);

    // Reset in the middle of activity
    bus.ex_ready = 1'b0;
    dec(6'd9, 4'd3, 32'd3, 4'd0, 32'd0, 4'd0);
    step();
    dec(6'd9, 4'd4, 32'd4, 4'd0, 32'd0, 4'd0);
    step();
    idle();
    chk("pre_rst_count", 32'(bus.count), 32'd1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("mid_rst_tag", 32'(bus.ex_tag), 32'd0);
    bus.ex_ready = 1'b1;
    step();
    step();
    chk("post_rst_valid", 32'(bus.ex_valid), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
